// File: rtl/page_resend_buffer_if.sv
// page_resend_buffer_if: leaf-side packet, resend and status signals of the page resend buffer.
interface page_resend_buffer_if #(
   parameter int PKT_W  = 49,
   parameter int ADDR_W = 4
);
   logic              ap_start;
   logic [PKT_W-1:0]  din_leaf_bft2interface;
   logic              resend;
   logic              flush;
   logic [PKT_W-1:0]  dout_leaf_interface2bft;
   logic              busy;
   logic [ADDR_W:0]   stored_count;
   logic              overflow;
   logic              dropped;
   modport master (
      output ap_start, din_leaf_bft2interface, resend, flush,
      input  dout_leaf_interface2bft, busy, stored_count, overflow, dropped
   );
   modport slave (
      input  ap_start, din_leaf_bft2interface, resend, flush,
      output dout_leaf_interface2bft, busy, stored_count, overflow, dropped
   );
endinterface

// File: rtl/page_resend_buffer.sv
// page_resend_buffer: circular history of valid BFT packets, replayed oldest-first on resend.
// Define PAGE_RESEND_PASSTHRU_EN to loop din back onto dout while capturing.
module page_resend_buffer #(
   parameter int PKT_W  = 49,
   parameter int ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   page_resend_buffer_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY} state_e;
   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]    count_q, count_d, rem_q, rem_d;
   logic [PKT_W-1:0]   dout_q, dout_d;
   logic               ovf_q, ovf_d, drop_q, drop_d, wr_en, vld;
   logic [PKT_W-1:0]   mem_q [DEPTH];
   assign vld = bus.din_leaf_bft2interface[PKT_W-1];
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rem_d    = rem_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      dout_d   = '0;
      wr_en    = 1'b0;
      case (state_q)
         IDLE: state_d = bus.ap_start ? CAPTURE : IDLE;
         CAPTURE: begin
`ifdef PAGE_RESEND_PASSTHRU_EN
            dout_d = bus.din_leaf_bft2interface;
`else
            dout_d = '0;
`endif
            if (bus.flush) begin
               count_d = '0;
               ovf_d   = 1'b0;
               drop_d  = 1'b0;
            end else begin
               if (vld) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  count_d  = (count_q == FULL) ? count_q : count_q + 1'b1;
                  ovf_d    = ovf_q | (count_q == FULL);
               end
               // snapshot includes a packet written in the same cycle as the resend
               if (bus.resend && count_d != '0) begin
                  state_d  = REPLAY;
                  rd_ptr_d = wr_ptr_d - count_d[ADDR_W-1:0];
                  rem_d    = count_d;
               end
            end
         end
         REPLAY: begin
            if (bus.flush) begin
               state_d = CAPTURE;
               count_d = '0;
               ovf_d   = 1'b0;
               drop_d  = 1'b0;
            end else begin
               dout_d   = mem_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + 1'b1;
               rem_d    = rem_q - 1'b1;
               drop_d   = drop_q | vld;
               state_d  = (rem_q == 1) ? CAPTURE : REPLAY;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rem_q    <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rem_q    <= rem_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= bus.din_leaf_bft2interface;
   end
   assign bus.dout_leaf_interface2bft = dout_q;
   assign bus.busy                    = (state_q == REPLAY);
   assign bus.stored_count            = count_q;
   assign bus.overflow                = ovf_q;
   assign bus.dropped                 = drop_q;
endmodule

// File: tb/tb_page_resend_buffer.sv
// tb_page_resend_buffer: directed stimulus with a replay scoreboard for page_resend_buffer.
module tb_page_resend_buffer;
   localparam int PKT_W  = 49;
   localparam int ADDR_W = 4;
   localparam logic [PKT_W-1:0] V = {1'b1, {(PKT_W-1){1'b0}}};
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [PKT_W-1:0] exp_q [$];
   logic [PKT_W-1:0] e;
   page_resend_buffer_if #(.PKT_W(PKT_W), .ADDR_W(ADDR_W)) bus ();
   page_resend_buffer #(.PKT_W(PKT_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );
   always #5 clk = ~clk;
   // any non-zero dout must be the next scoreboard entry
   always @(negedge clk) begin
      if (mon_en && bus.dout_leaf_interface2bft !== '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL replay_unexpected got=%h expected no output", bus.dout_leaf_interface2bft);
         end else begin
            e = exp_q.pop_front();
            if (bus.dout_leaf_interface2bft !== e) begin
               errors++;
               $display("FAIL replay_data got=%h expected=%h", bus.dout_leaf_interface2bft, e);
            end
         end
      end
   end
   task automatic check(input string n, input logic [63:0] a, input logic [63:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", n, a, x);
      end
   endtask
   task automatic cyc(input logic [PKT_W-1:0] d, input logic rs, input logic fl, input logic ap);
      bus.din_leaf_bft2interface = d;
      bus.resend = rs;
      bus.flush = fl;
      bus.ap_start = ap;
      @(posedge clk);
      #1;
      bus.din_leaf_bft2interface = '0;
      bus.resend = 1'b0;
      bus.flush = 1'b0;
      bus.ap_start = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) cyc('0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask
   task automatic send3();
      cyc('0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 3; i++) cyc(V | PKT_W'(i), 1'b0, 1'b0, 1'b0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.din_leaf_bft2interface = '0;
      bus.resend = 1'b0;
      bus.flush = 1'b0;
      bus.ap_start = 1'b0;
      do_reset();
      mon_en = 1'b1;
      check("reset_count", 64'(bus.stored_count), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
      // basic 3-entry replay with exact timing
      send3();
      for (int i = 1; i <= 3; i++) exp_q.push_back(V | PKT_W'(i));
      cyc('0, 1'b1, 1'b0, 1'b0);
      check("t1_busy", 64'(bus.busy), 64'd1);
      idle(1);
      check("t2_busy", 64'(bus.busy), 64'd1);
      idle(1);
      check("t3_busy", 64'(bus.busy), 64'd1);
      idle(1);
      check("t4_busy", 64'(bus.busy), 64'd0);
      check("t4_dout", 64'(bus.dout_leaf_interface2bft), 64'(V | 49'd3));
      idle(1);
      check("t5_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
      check("t1_drained", 64'(exp_q.size()), 64'd0);
      check("t1_count", 64'(bus.stored_count), 64'd3);
      // overflow: 20 writes keep the newest 16
      do_reset();
      cyc('0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) cyc(V | PKT_W'(i), 1'b0, 1'b0, 1'b0);
      check("ovf_count", 64'(bus.stored_count), 64'd16);
      check("ovf_flag", 64'(bus.overflow), 64'd1);
      for (int i = 5; i <= 20; i++) exp_q.push_back(V | PKT_W'(i));
      cyc('0, 1'b1, 1'b0, 1'b0);
      idle(18);
      check("ovf_drained", 64'(exp_q.size()), 64'd0);
      check("ovf_count_after", 64'(bus.stored_count), 64'd16);
      cyc(V | 49'hDEAD_BEEF_0001, 1'b0, 1'b0, 1'b0);
      check("no_passthru", 64'(bus.dout_leaf_interface2bft), 64'd0);
      cyc('0, 1'b1, 1'b1, 1'b0);
      check("flush_busy", 64'(bus.busy), 64'd0);
      check("flush_count", 64'(bus.stored_count), 64'd0);
      check("flush_ovf", 64'(bus.overflow), 64'd0);
      idle(2);
      check("flush_busy_later", 64'(bus.busy), 64'd0);
      // resend with nothing stored
      do_reset();
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc('0, 1'b1, 1'b0, 1'b0);
      check("empty_busy", 64'(bus.busy), 64'd0);
      idle(2);
      check("empty_busy_later", 64'(bus.busy), 64'd0);
      check("empty_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
      // packet during replay is dropped, not stored
      do_reset();
      send3();
      for (int i = 1; i <= 3; i++) exp_q.push_back(V | PKT_W'(i));
      cyc('0, 1'b1, 1'b0, 1'b0);
      cyc(V | 49'hAA, 1'b0, 1'b0, 1'b0);
      check("drop_flag", 64'(bus.dropped), 64'd1);
      idle(4);
      check("drop_count", 64'(bus.stored_count), 64'd3);
      check("drop_drained1", 64'(exp_q.size()), 64'd0);
      for (int i = 1; i <= 3; i++) exp_q.push_back(V | PKT_W'(i));
      cyc('0, 1'b1, 1'b0, 1'b0);
      idle(5);
      check("drop_drained2", 64'(exp_q.size()), 64'd0);
      check("drop_sticky", 64'(bus.dropped), 64'd1);
      // flush aborts an active replay
      exp_q.push_back(V | 49'd1);
      cyc('0, 1'b1, 1'b0, 1'b0);
      idle(1);
      cyc('0, 1'b0, 1'b1, 1'b0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
      check("abort_count", 64'(bus.stored_count), 64'd0);
      check("abort_drop", 64'(bus.dropped), 64'd0);
      idle(3);
      check("abort_drained", 64'(exp_q.size()), 64'd0);
      // reset in the second replay cycle
      do_reset();
      send3();
      exp_q.push_back(V | 49'd1);
      cyc('0, 1'b1, 1'b0, 1'b0);
      idle(1);
      do_reset();
      check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_count", 64'(bus.stored_count), 64'd0);
      cyc(V | 49'd7, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("idle_ignores_din", 64'(bus.stored_count), 64'd0);
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc('0, 1'b1, 1'b0, 1'b0);
      check("rst_no_replay", 64'(bus.busy), 64'd0);
      idle(2);
      check("rst_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
